// File: rtl/perceptron_trainer.sv
// N_IN-input perceptron trainer: sequential MAC, epochs until zero errors or max_epochs; PTRAIN_MARGIN_EN adds a margin port.
// Per sample N_IN+2 cycles (N_IN+3 with update); the source is stalled by holding req high until data_valid.
module perceptron_trainer #(
  parameter int N_IN    = 4,
  parameter int DW      = 8,
  parameter int WW      = 16,
  parameter int EPOCH_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EPOCH_W-1:0]   max_epochs,
  output logic                 req,
  input  logic                 data_valid,
  input  logic [N_IN*DW-1:0]   x_flat,
  input  logic                 t,
  input  logic                 last,
`ifdef PTRAIN_MARGIN_EN
  input  logic [WW-1:0]        margin,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [EPOCH_W-1:0]   epoch_cnt,
  output logic [15:0]          err_cnt,
  output logic [N_IN*WW-1:0]   w_flat,
  output logic [WW-1:0]        bias
);
  localparam int AW = WW + DW + $clog2(N_IN + 1);
  localparam int PW = WW + DW;
  localparam int SW = ((WW > DW) ? WW : DW) + 2;
  localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_REQ, S_MAC, S_CLASSIFY, S_UPDATE, S_EPOCH_END
  } state_t;

  state_t               state_q, state_d;
  logic signed [WW-1:0] w_q [N_IN];
  logic signed [WW-1:0] w_d [N_IN];
  logic signed [WW-1:0] bias_q, bias_d;
  logic signed [DW-1:0] x_q [N_IN];
  logic signed [DW-1:0] x_d [N_IN];
  logic                 t_q, t_d, last_q, last_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [KW-1:0]        k_q, k_d;
  logic [EPOCH_W-1:0]   epoch_cnt_q, epoch_cnt_d;
  logic [EPOCH_W-1:0]   max_ep_q, max_ep_d;
  logic [15:0]          err_cnt_q, err_cnt_d;
  logic                 converged_q, converged_d;

  logic signed [PW-1:0] prod;
  logic signed [WW-1:0] upd_w [N_IN];
  logic signed [WW-1:0] upd_bias;
  logic                 below_margin;

  // Clamp a widened sum back into the signed WW range instead of wrapping.
  function automatic logic signed [WW-1:0] sat_w(input logic signed [SW-1:0] v);
    if (v[SW-1:WW-1] == {(SW-WW+1){v[SW-1]}})
      sat_w = v[WW-1:0];
    else if (v[SW-1])
      sat_w = {1'b1, {(WW-1){1'b0}}};
    else
      sat_w = {1'b0, {(WW-1){1'b1}}};
  endfunction

  assign prod = PW'(w_q[k_q]) * PW'(x_q[k_q]);

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      upd_w[i] = sat_w(t_q ? (SW'(w_q[i]) + SW'(x_q[i])) : (SW'(w_q[i]) - SW'(x_q[i])));
    end
    upd_bias = sat_w(t_q ? (SW'(bias_q) + SW'(1)) : (SW'(bias_q) - SW'(1)));
  end

`ifdef PTRAIN_MARGIN_EN
  logic [AW-1:0] acc_abs;
  // The most negative acc negates to itself, which reads correctly as an unsigned magnitude.
  assign acc_abs      = acc_q[AW-1] ? -acc_q : acc_q;
  assign below_margin = (acc_abs < {{(AW-WW){1'b0}}, margin});
`else
  assign below_margin = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    bias_d      = bias_q;
    x_d         = x_q;
    t_d         = t_q;
    last_d      = last_q;
    acc_d       = acc_q;
    k_d         = k_q;
    epoch_cnt_d = epoch_cnt_q;
    max_ep_d    = max_ep_q;
    err_cnt_d   = err_cnt_q;
    converged_d = converged_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        for (int i = 0; i < N_IN; i++) w_d[i] = '0;
        bias_d      = '0;
        epoch_cnt_d = '0;
        err_cnt_d   = '0;
        converged_d = 1'b0;
        max_ep_d    = max_epochs;
        state_d     = S_REQ;
      end
      S_REQ: begin
        if (data_valid) begin
          for (int i = 0; i < N_IN; i++) x_d[i] = x_flat[i*DW +: DW];
          t_d     = t;
          last_d  = last;
          acc_d   = AW'(bias_q);
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + AW'(prod);
        k_d   = k_q + 1'b1;
        if (k_q == KW'(N_IN - 1)) state_d = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        if ((~acc_q[AW-1]) != t_q || below_margin) state_d = S_UPDATE;
        else if (last_q)                           state_d = S_EPOCH_END;
        else                                       state_d = S_REQ;
      end
      S_UPDATE: begin
        w_d    = upd_w;
        bias_d = upd_bias;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        state_d = last_q ? S_EPOCH_END : S_REQ;
      end
      S_EPOCH_END: begin
        epoch_cnt_d = epoch_cnt_q + 1'b1;
        if (err_cnt_q == 16'd0) begin
          converged_d = 1'b1;
          state_d     = S_IDLE;
        end else if (max_ep_q != '0 && epoch_cnt_d == max_ep_q) begin
          converged_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          err_cnt_d = '0;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
      bias_q      <= '0;
      t_q         <= 1'b0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      k_q         <= '0;
      epoch_cnt_q <= '0;
      max_ep_q    <= '0;
      err_cnt_q   <= '0;
      converged_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      x_q         <= x_d;
      bias_q      <= bias_d;
      t_q         <= t_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      epoch_cnt_q <= epoch_cnt_d;
      max_ep_q    <= max_ep_d;
      err_cnt_q   <= err_cnt_d;
      converged_q <= converged_d;
    end
  end

  assign req       = (state_q == S_REQ);
  assign done      = (state_q == S_IDLE);
  assign busy      = ~done;
  assign converged = converged_q;
  assign epoch_cnt = epoch_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign bias      = bias_q;

  always_comb begin
    for (int i = 0; i < N_IN; i++) w_flat[i*WW +: WW] = w_q[i];
  end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
Parametrised successor to the two-input neuron training controller. It integrates the control FSM and datapath for an N_IN-input perceptron, and trains weights and bias from a handshaked sample stream. A sequential MAC computes one product per cycle. Training runs over repeated epochs until an epoch completes with zero errors or an epoch limit is reached. It sits between the sample-memory reader, which supplies samples, and the host, which starts training and reads back the weights.

Parameters:
N_IN, 4, number of inputs (>=1)
DW, 8, signed sample element width
WW, 16, signed weight/bias width
EPOCH_W, 8, epoch counter and limit width

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
start  in  1  begin training; sampled only in IDLE
max_epochs  in  EPOCH_W  epoch limit; 0 = unlimited; sampled in INIT
req  out  1  sample request to source
data_valid  in  1  source has sample; accepted only while req=1
x_flat  in  N_IN*DW  signed samples, element i at [i*DW +: DW]
t  in  1  target: 1 = +1, 0 = -1
last  in  1  sample is last of epoch
busy  out  1  high in every state except IDLE
done  out  1  high in IDLE (matches predecessor)
converged  out  1  last run ended with a zero-error epoch
epoch_cnt  out  EPOCH_W  completed epochs
err_cnt  out  16  errors in the current/last epoch, saturating at 16'hFFFF
w_flat  out  N_IN*WW  weights, element i at [i*WW +: WW]
bias  out  WW  bias

Behaviour:
- Reset, async, at any time including mid-epoch: state=IDLE; req=0, busy=0, done=1, converged=0, epoch_cnt=0, err_cnt=0, w=0, bias=0. Reset never leaves partial state behind.
- States: IDLE, INIT, REQ, MAC, CLASSIFY, UPDATE, EPOCH_END.
- IDLE: done=1. start=1 -> INIT. converged, weights and counters hold their values from the last run.
- INIT (1 cycle): clear w, bias, epoch_cnt, err_cnt and converged; latch max_epochs -> REQ.
- REQ: req=1. On the cycle where data_valid=1, capture x, t and last, set req=0 the next cycle -> MAC.
- MAC (exactly N_IN cycles): cycle k adds w[k]*x[k] to acc. acc starts at sign-extended bias.
  - acc width = WW+DW+clog2(N_IN+1); no truncation.
- CLASSIFY (1 cycle): y = (acc >= 0).
  - y != t -> UPDATE.
  - Otherwise, last=1 -> EPOCH_END; else -> REQ.
- UPDATE (1 cycle): all weights update in parallel.
  - t=1: w[i] += x[i], bias += 1. t=0: w[i] -= x[i], bias -= 1.
  - Each result saturates to the signed WW range; no wrap.
  - err_cnt += 1.
  - Next: last=1 -> EPOCH_END; else -> REQ.
- EPOCH_END (1 cycle): epoch_cnt += 1.
  - err_cnt == 0 -> converged=1, IDLE.
  - Else if max_epochs != 0 and epoch_cnt+1 == max_epochs -> converged=0, IDLE.
  - Else clear err_cnt -> REQ.
- epoch_cnt wraps at 2^EPOCH_W only when max_epochs=0.
- Per-sample latency from handshake to next req: N_IN+2 cycles when correct, N_IN+3 when an update occurs.
- start while busy: ignored. data_valid while req=0: ignored, source must hold.
- err_cnt holds its final value in IDLE.

Optional Feature:
PTRAIN_MARGIN_EN:
- Defined: adds input port margin[WW-1:0] (unsigned). CLASSIFY also goes to UPDATE when y == t but |acc| < margin. The update uses the same rule and increments err_cnt.
- Undefined: no margin port; update only on misclassification, exactly as described above.

Test Plan:
- AND gate, N_IN=2, epoch of (1,1,t=1), (1,-1,t=0), (-1,1,t=0), (-1,-1,t=0) with last on the 4th, max_epochs=0 -> err_cnt per epoch 2, 1, 0; converged=1, epoch_cnt=3, w=(1,1), bias=-1, done=1.
- Saturation, N_IN=1, DW=WW=8, single sample x=-128, t=0, last=1 -> epoch1 w=127 (not -128), bias=-1; epoch2 error-free; converged=1, epoch_cnt=2.
- Limit: XOR dataset, max_epochs=5 -> stops with epoch_cnt=5, converged=0, err_cnt>0, done=1.
- Handshake: hold data_valid=0 for 10 cycles in REQ -> req stays 1, no state change. A data_valid pulse while req=0 is ignored.
- Reset mid-MAC: assert rst during the 2nd MAC cycle -> same cycle, all outputs at reset values. start afterwards trains from zero weights and reproduces the AND result.
- PTRAIN_MARGIN_EN, margin=2, AND dataset -> trains until every |acc| >= 2. Final weights differ from the no-macro build, and converged=1.
